// File: rtl/check_reg_bank_if.sv
// Sample/control bundle between the operand sources and the check_reg_bank capture register.
interface check_reg_bank_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 4
);
    logic             start;
    logic             mode;
    logic             valid_in;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic             q_valid;
    logic             sel_a;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             done;

    modport master (
        output start, mode, valid_in, a, d,
        input  q, q_valid, sel_a, count, busy, done
    );

    modport slave (
        input  start, mode, valid_in, a, d,
        output q, q_valid, sel_a, count, busy, done
    );
endinterface

// File: rtl/check_reg_bank.sv
// Capture register framing a fixed burst of CNT_MAX+1 samples; loads from `a` when
// the index of the accepted sample falls in [LOAD_LO, LOAD_HI], else from `d`.
module check_reg_bank #(
    parameter int WIDTH   = 32,
    parameter int CNT_W   = 4,
    parameter int CNT_MAX = 15,
    parameter int LOAD_LO = 7,
    parameter int LOAD_HI = 8
) (
    input logic              clk,
    input logic              reset,
    check_reg_bank_if.slave  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    localparam logic [CNT_W-1:0] MAX_C = CNT_W'(CNT_MAX);
    localparam logic [CNT_W-1:0] LO_C  = CNT_W'(LOAD_LO);
    localparam logic [CNT_W-1:0] HI_C  = CNT_W'(LOAD_HI);

    logic [1:0]       state_q,   state_d;
    logic [WIDTH-1:0] q_q,       q_d;
    logic             q_valid_q, q_valid_d;
    logic             sel_a_q,   sel_a_d;
    logic [CNT_W-1:0] count_q,   count_d;
    logic             busy_q,    busy_d;
    logic             done_q,    done_d;
    logic             hit;

    // Window test uses the index of the sample being accepted, before the increment.
    assign hit = !bus.mode && (count_q >= LO_C) && (count_q <= HI_C);

    always_comb begin
        state_d   = state_q;
        q_d       = q_q;
        sel_a_d   = sel_a_q;
        count_d   = count_q;
        q_valid_d = 1'b0;
        busy_d    = 1'b0;
        done_d    = 1'b0;
        case (state_q)
            S_IDLE: begin
                count_d = '0;
                if (bus.start) begin
                    state_d = S_RUN;
                    busy_d  = 1'b1;
                end
            end
            S_RUN: begin
                busy_d = 1'b1;
                if (bus.valid_in) begin
                    q_d       = hit ? bus.a : bus.d;
                    sel_a_d   = hit;
                    q_valid_d = 1'b1;
                    if (count_q == MAX_C) begin
                        count_d = '0;
                        state_d = S_DONE;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        count_d = count_q + CNT_W'(1);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                count_d = '0;
            end
        endcase
    end

    // Every output is a flop; busy/done are computed one cycle early so they line up with state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            q_q       <= '0;
            q_valid_q <= 1'b0;
            sel_a_q   <= 1'b0;
            count_q   <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            q_q       <= q_d;
            q_valid_q <= q_valid_d;
            sel_a_q   <= sel_a_d;
            count_q   <= count_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.q       = q_q;
    assign bus.q_valid = q_valid_q;
    assign bus.sel_a   = sel_a_q;
    assign bus.count   = count_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
endmodule

// File: tb/tb_check_reg_bank.sv
// Directed-vector bench for check_reg_bank: bursts in windowed, bypass, gapped,
// mid-burst reset and start-noise scenarios with hand-computed expectations.
module tb_check_reg_bank;
    logic clk;
    logic reset;
    int   nTotal;
    int   nBad;

    check_reg_bank_if #(.WIDTH(32), .CNT_W(4)) bus ();

    check_reg_bank #(
        .WIDTH(32), .CNT_W(4), .CNT_MAX(15), .LOAD_LO(7), .LOAD_HI(8)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nTotal++;
        if (obs !== exp) begin
            nBad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Inputs change on the falling edge; outputs are looked at 1ns after the rising edge.
    task automatic applyStimulus(input logic rst, input logic st, input logic md,
                                 input logic vld, input logic [31:0] aa, input logic [31:0] dd);
        @(negedge clk);
        reset        = rst;
        bus.start    = st;
        bus.mode     = md;
        bus.valid_in = vld;
        bus.a        = aa;
        bus.d        = dd;
        @(posedge clk);
        #1;
    endtask

    task automatic runBurst(input logic md, input bit gapped, input bit noise);
        logic [31:0] expQ;
        logic        expSel;
        applyStimulus(1'b0, 1'b1, md, 1'b1, 32'hBAD0BAD0, 32'h0000_0055);
        checkOutput("start_busy",   32'(bus.busy),    32'd1);
        checkOutput("start_count",  32'(bus.count),   32'd0);
        checkOutput("start_qvalid", 32'(bus.q_valid), 32'd0);
        for (int i = 0; i < 16; i++) begin
            applyStimulus(1'b0, noise && (i == 5), md, 1'b1, 32'hA00 + i, 32'h100 + i);
            expSel = !md && (i >= 7) && (i <= 8);
            expQ   = expSel ? 32'hA00 + i : 32'h100 + i;
            checkOutput("q",       bus.q,               expQ);
            checkOutput("sel_a",   32'(bus.sel_a),      32'(expSel));
            checkOutput("q_valid", 32'(bus.q_valid),    32'd1);
            checkOutput("count",   32'(bus.count),      (i == 15) ? 32'd0 : 32'(i + 1));
            checkOutput("done",    32'(bus.done),       32'(i == 15));
            checkOutput("busy",    32'(bus.busy),       32'(i != 15));
            if (gapped && i != 15) begin
                applyStimulus(1'b0, noise, md, 1'b0, 32'hFFFF_FFFF, 32'hEEEE_EEEE);
                checkOutput("gap_q",      bus.q,            expQ);
                checkOutput("gap_sel_a",  32'(bus.sel_a),   32'(expSel));
                checkOutput("gap_qvalid", 32'(bus.q_valid), 32'd0);
                checkOutput("gap_count",  32'(bus.count),   32'(i + 1));
                checkOutput("gap_busy",   32'(bus.busy),    32'd1);
            end
        end
        applyStimulus(1'b0, noise, md, 1'b0, 32'h0, 32'h0);
        checkOutput("post_done",   32'(bus.done),    32'd0);
        checkOutput("post_busy",   32'(bus.busy),    32'd0);
        checkOutput("post_q",      bus.q,            32'h10F);
        checkOutput("post_qvalid", 32'(bus.q_valid), 32'd0);
        checkOutput("post_count",  32'(bus.count),   32'd0);
        applyStimulus(1'b0, 1'b0, md, 1'b1, 32'h0, 32'h0);
        checkOutput("idle_done", 32'(bus.done),    32'd0);
        checkOutput("idle_busy", 32'(bus.busy),    32'd0);
        checkOutput("idle_qv",   32'(bus.q_valid), 32'd0);
    endtask

    initial begin
        nTotal       = 0;
        nBad         = 0;
        reset        = 1'b1;
        bus.start    = 1'b0;
        bus.mode     = 1'b0;
        bus.valid_in = 1'b0;
        bus.a        = '0;
        bus.d        = '0;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0);

        // Load a known value, then reset together with start: reset must win.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hDEADBEEF, 32'hDEADBEEF);
        checkOutput("load_q", bus.q, 32'hDEADBEEF);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 32'h1, 32'h1);
        checkOutput("rst_q",      bus.q,            32'h0);
        checkOutput("rst_count",  32'(bus.count),   32'd0);
        checkOutput("rst_qvalid", 32'(bus.q_valid), 32'd0);
        checkOutput("rst_sel_a",  32'(bus.sel_a),   32'd0);
        checkOutput("rst_busy",   32'(bus.busy),    32'd0);
        checkOutput("rst_done",   32'(bus.done),    32'd0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h2, 32'h2);
        checkOutput("rst_idle_busy", 32'(bus.busy),    32'd0);
        checkOutput("rst_idle_qv",   32'(bus.q_valid), 32'd0);
        checkOutput("rst_idle_q",    bus.q,            32'h0);

        runBurst(1'b0, 1'b0, 1'b0);
        runBurst(1'b1, 1'b0, 1'b0);
        runBurst(1'b0, 1'b1, 1'b0);

        // Abandon a burst after sample 9 with reset; no done may follow.
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
        for (int i = 0; i < 10; i++)
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'hA00 + i, 32'h100 + i);
        checkOutput("mid_count", 32'(bus.count), 32'd10);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
        checkOutput("mid_rst_q",     bus.q,            32'h0);
        checkOutput("mid_rst_count", 32'(bus.count),   32'd0);
        checkOutput("mid_rst_busy",  32'(bus.busy),    32'd0);
        checkOutput("mid_rst_qv",    32'(bus.q_valid), 32'd0);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
            checkOutput("mid_idle_done",  32'(bus.done),  32'd0);
            checkOutput("mid_idle_count", 32'(bus.count), 32'd0);
        end

        runBurst(1'b0, 1'b0, 1'b1);

        $display("test done: total=%0d bad=%0d", nTotal, nBad);
        $finish;
    end
endmodule
